// File: rtl/host_tx_delay_check.sv
// Transmit-side residence-delay check for descriptors stamped by the wrapping host timer.
// One descriptor in flight at a time: capture, compute delay and verdict, hand off downstream.
module host_tx_delay_check #(
   parameter logic [18:0] TIMER_MAX = 19'd499999,
   parameter logic [18:0] MAX_DELAY = 19'd250000,
   parameter int          DESC_W    = 16,
   parameter int          CNT_W     = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [18:0]       iv_timer,
   input  logic [DESC_W-1:0] iv_desc,
   input  logic [18:0]       iv_rx_timestamp,
   input  logic              i_desc_wr,
   output logic              o_desc_ready,
   output logic [DESC_W-1:0] ov_desc,
   output logic [18:0]       ov_delay,
   output logic              o_discard,
   output logic              o_desc_wr,
   input  logic              i_desc_ready,
   output logic [CNT_W-1:0]  ov_forward_cnt,
   output logic [CNT_W-1:0]  ov_discard_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              accept;
   logic              xfer;
   logic [DESC_W-1:0] desc_p0;
   logic [18:0]       ts_p0;
   logic [18:0]       now_p0;
   logic [18:0]       delay_calc;
   logic              discard_calc;

   // Delay modulo the timer period; an out-of-range stamp yields all ones.
   function automatic logic [18:0] residence_delay(input logic [18:0] ts, input logic [18:0] now);
      logic [19:0] wrapped;
      wrapped = {1'b0, now} + {1'b0, TIMER_MAX} + 20'd1 - {1'b0, ts};
      if (ts > TIMER_MAX)
         return '1;
      else if (now >= ts)
         return now - ts;
      else
         return wrapped[18:0];
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign accept       = (state == IDLE) && i_desc_wr;
   assign xfer         = (state == OUT) && i_desc_ready;
   assign delay_calc   = residence_delay(ts_p0, now_p0);
   assign discard_calc = (ts_p0 > TIMER_MAX) || (delay_calc > MAX_DELAY);

   always_comb begin
      state_next   = state;
      o_desc_ready = 1'b0;
      o_desc_wr    = 1'b0;
      case (state)
         IDLE: begin
            o_desc_ready = i_rst_n;
            if (i_desc_wr)
               state_next = CALC;
         end
         CALC: state_next = OUT;
         OUT: begin
            o_desc_wr = 1'b1;
            if (i_desc_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Stage 0: capture descriptor, stamp and the timer sample of the accept cycle
   always_ff @(posedge i_clk) begin
      if (accept) begin
         desc_p0 <= iv_desc;
         ts_p0   <= iv_rx_timestamp;
         now_p0  <= iv_timer;
      end
   end

   // Stage 1: registered result, held through backpressure; counters bump on transfer
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state          <= IDLE;
         ov_desc        <= '0;
         ov_delay       <= '0;
         o_discard      <= 1'b0;
         ov_forward_cnt <= '0;
         ov_discard_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == CALC) begin
            ov_desc   <= desc_p0;
            ov_delay  <= delay_calc;
            o_discard <= discard_calc;
         end
         if (xfer) begin
            if (o_discard)
               ov_discard_cnt <= sat_inc(ov_discard_cnt);
            else
               ov_forward_cnt <= sat_inc(ov_forward_cnt);
         end
      end
   end

endmodule

// File: tb/tb_host_tx_delay_check.sv
// Bench for host_tx_delay_check: vector table through a scoreboard, plus backpressure,
// reset-in-flight and counter saturation (on a narrow-counter instance).
module tb_host_tx_delay_check;

   typedef struct {
      logic [15:0] desc;
      logic [18:0] ts;
      logic [18:0] now;
      logic [18:0] delay;
      logic        discard;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [18:0] timer;
   logic [15:0] desc_in;
   logic [18:0] ts_in;
   logic        wr_in;
   logic        ready_out;
   logic [15:0] desc_out;
   logic [18:0] delay_out;
   logic        discard_out;
   logic        wr_out;
   logic        ready_in;
   logic [15:0] fwd_cnt;
   logic [15:0] disc_cnt;

   logic [18:0] s_timer;
   logic [15:0] s_desc_in;
   logic [18:0] s_ts_in;
   logic        s_wr_in;
   logic        s_ready_out;
   logic [15:0] s_desc_out;
   logic [18:0] s_delay_out;
   logic        s_discard_out;
   logic        s_wr_out;
   logic        s_ready_in;
   logic [2:0]  s_fwd_cnt;
   logic [2:0]  s_disc_cnt;

   vec_t        vecs[12];
   vec_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_fwd = 16'd0;
   logic [15:0] exp_disc = 16'd0;

   always #5 clk = ~clk;

   host_tx_delay_check dut (
      .i_clk(clk), .i_rst_n(rst_n), .iv_timer(timer), .iv_desc(desc_in),
      .iv_rx_timestamp(ts_in), .i_desc_wr(wr_in), .o_desc_ready(ready_out),
      .ov_desc(desc_out), .ov_delay(delay_out), .o_discard(discard_out),
      .o_desc_wr(wr_out), .i_desc_ready(ready_in),
      .ov_forward_cnt(fwd_cnt), .ov_discard_cnt(disc_cnt)
   );

   host_tx_delay_check #(.CNT_W(3)) dut_sat (
      .i_clk(clk), .i_rst_n(rst_n), .iv_timer(s_timer), .iv_desc(s_desc_in),
      .iv_rx_timestamp(s_ts_in), .i_desc_wr(s_wr_in), .o_desc_ready(s_ready_out),
      .ov_desc(s_desc_out), .ov_delay(s_delay_out), .o_discard(s_discard_out),
      .o_desc_wr(s_wr_out), .i_desc_ready(s_ready_in),
      .ov_forward_cnt(s_fwd_cnt), .ov_discard_cnt(s_disc_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] sat16(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   // Monitor: every handshake pops the oldest expected record
   always @(negedge clk) begin
      if (rst_n && wr_out && ready_in) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
         end else begin
            vec_t e;
            e = sb.pop_front();
            chk("out_desc", desc_out, e.desc);
            chk("out_delay", delay_out, e.delay);
            chk("out_discard", discard_out, e.discard);
            chk("pre_fwd_cnt", fwd_cnt, exp_fwd);
            chk("pre_disc_cnt", disc_cnt, exp_disc);
            if (e.discard) exp_disc = sat16(exp_disc);
            else           exp_fwd  = sat16(exp_fwd);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready_out && n < 20) begin
         step();
         n++;
      end
      if (!ready_out) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic accept(input vec_t v);
      wait_ready();
      wr_in   = 1'b1;
      desc_in = v.desc;
      ts_in   = v.ts;
      timer   = v.now;
      sb.push_back(v);
      step();
      wr_in = 1'b0;
      timer = 19'($urandom_range(0, 499999));
   endtask

   task automatic send(input vec_t v);
      accept(v);
      chk("calc_wr", wr_out, 1'b0);
      chk("calc_ready", ready_out, 1'b0);
      step();
      chk("latency_wr", wr_out, 1'b1);
      step();
   endtask

   task automatic send_s(input logic [18:0] ts, input logic [18:0] now);
      int n = 0;
      while (!s_ready_out && n < 20) begin
         step();
         n++;
      end
      if (!s_ready_out) chk("sat_ready_timeout", 32'd0, 32'd1);
      s_wr_in   = 1'b1;
      s_ts_in   = ts;
      s_timer   = now;
      s_desc_in = 16'h0101;
      step();
      s_wr_in = 1'b0;
      step();
      step();
   endtask

   initial begin
      vecs[0]  = '{16'h0001, 19'd100,    19'd350,    19'd250,     1'b0};
      vecs[1]  = '{16'h0002, 19'd499900, 19'd100,    19'd200,     1'b0};
      vecs[2]  = '{16'h0003, 19'd499999, 19'd0,      19'd1,       1'b0};
      vecs[3]  = '{16'h0004, 19'd0,      19'd250000, 19'd250000,  1'b0};
      vecs[4]  = '{16'h0005, 19'd0,      19'd250001, 19'd250001,  1'b1};
      vecs[5]  = '{16'h0006, 19'd499999, 19'd250000, 19'd250001,  1'b1};
      vecs[6]  = '{16'h0007, 19'd500000, 19'd5,      19'h7FFFF,   1'b1};
      vecs[7]  = '{16'hA5A5, 19'd12345,  19'd12345,  19'd0,       1'b0};
      vecs[8]  = '{16'h0009, 19'h7FFFF,  19'd0,      19'h7FFFF,   1'b1};
      vecs[9]  = '{16'h1234, 19'd250000, 19'd499999, 19'd249999,  1'b0};
      vecs[10] = '{16'hFFFF, 19'd1,      19'd0,      19'd499999,  1'b1};
      vecs[11] = '{16'h8000, 19'd250000, 19'd0,      19'd250000,  1'b0};

      rst_n = 1'b0; ready_in = 1'b1; wr_in = 1'b0; desc_in = '0; ts_in = '0; timer = '0;
      s_ready_in = 1'b1; s_wr_in = 1'b0; s_desc_in = '0; s_ts_in = '0; s_timer = '0;
      repeat (3) step();
      chk("rst_ready", ready_out, 1'b0);
      chk("rst_wr", wr_out, 1'b0);
      chk("rst_discard", discard_out, 1'b0);
      chk("rst_desc", desc_out, 16'h0);
      chk("rst_delay", delay_out, 19'h0);
      chk("rst_fwd_cnt", fwd_cnt, 16'h0);
      chk("rst_disc_cnt", disc_cnt, 16'h0);
      rst_n = 1'b1;
      #1;
      chk("idle_ready", ready_out, 1'b1);

      for (int i = 0; i < 12; i++) send(vecs[i]);
      chk("vec_fwd_cnt", fwd_cnt, exp_fwd);
      chk("vec_disc_cnt", disc_cnt, exp_disc);
      chk("vec_sb_empty", sb.size(), 0);

      // Backpressure: result held, new requests ignored, count only on release
      begin
         vec_t bp;
         logic [15:0] fwd_before;
         bp = '{16'hB00B, 19'd1000, 19'd1500, 19'd500, 1'b0};
         ready_in = 1'b0;
         accept(bp);
         step();
         fwd_before = exp_fwd;
         for (int i = 0; i < 5; i++) begin
            wr_in = 1'b1; desc_in = 16'hDEAD; ts_in = 19'd0; timer = 19'd7;
            chk("bp_wr", wr_out, 1'b1);
            chk("bp_ready", ready_out, 1'b0);
            chk("bp_desc", desc_out, 16'hB00B);
            chk("bp_delay", delay_out, 19'd500);
            chk("bp_discard", discard_out, 1'b0);
            chk("bp_fwd_cnt", fwd_cnt, fwd_before);
            step();
         end
         wr_in = 1'b0;
         ready_in = 1'b1;
         step();
         chk("bp_release_cnt", fwd_cnt, fwd_before + 16'd1);
         chk("bp_release_ready", ready_out, 1'b1);
         step();
         step();
         chk("bp_ignored_wr", wr_out, 1'b0);
         chk("bp_sb_empty", sb.size(), 0);
      end

      // Reset while a descriptor is in CALC drops it
      accept('{16'h5A5A, 19'd10, 19'd20, 19'd10, 1'b0});
      rst_n = 1'b0;
      step();
      chk("rcalc_wr", wr_out, 1'b0);
      chk("rcalc_ready", ready_out, 1'b0);
      chk("rcalc_fwd_cnt", fwd_cnt, 16'h0);
      chk("rcalc_disc_cnt", disc_cnt, 16'h0);
      chk("rcalc_desc", desc_out, 16'h0);
      chk("rcalc_delay", delay_out, 19'h0);
      sb.delete();
      exp_fwd = 16'd0;
      exp_disc = 16'd0;
      rst_n = 1'b1;
      #1;
      chk("rcalc_idle_ready", ready_out, 1'b1);
      step();
      step();
      chk("rcalc_no_output", wr_out, 1'b0);
      send('{16'h7777, 19'd400000, 19'd400003, 19'd3, 1'b0});
      chk("recover_fwd_cnt", fwd_cnt, 16'd1);

      // Saturation on the 3-bit counter instance
      for (int k = 1; k <= 8; k++) begin
         send_s(19'd0, 19'd10);
         chk("sat_fwd_cnt", s_fwd_cnt, (k > 7) ? 3'd7 : 3'(k));
      end
      chk("sat_disc_idle", s_disc_cnt, 3'd0);
      send_s(19'd500000, 19'd0);
      chk("sat_disc_cnt", s_disc_cnt, 3'd1);
      chk("sat_fwd_hold", s_fwd_cnt, 3'd7);

      chk("final_fwd_cnt", fwd_cnt, exp_fwd);
      chk("final_disc_cnt", disc_cnt, exp_disc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
